// File: rtl/entropy_collector.sv
`default_nettype none
// ============================================================================
// Module  : entropy_collector
// Brief   : Entropy-source consumer with repetition-count health test; packs
//           NUM_WORDS accepted 32-bit words into one block for the mixer.
// Revision: 1.0 - initial release
// ============================================================================
module entropy_collector #(
  parameter int NUM_WORDS = 16,
  parameter int REP_LIMIT = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      entropy_enabled,
  input  logic                      entropy_syn,
  input  logic [31:0]               entropy_data,
  output logic                      entropy_ack,
  output logic                      block_valid,
  output logic [32*NUM_WORDS-1:0]   block_data,
  input  logic                      block_ready,
  output logic                      rep_fail,
  output logic [31:0]               word_count
);

  localparam int c_idx_w = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int c_rep_w = $clog2(REP_LIMIT + 1);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(NUM_WORDS - 1);
  localparam logic [c_rep_w-1:0] c_rep_limit = c_rep_w'(REP_LIMIT);
  localparam logic [c_rep_w-1:0] c_rep_one   = c_rep_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACK  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [c_idx_w-1:0]      r_idx;
  logic [c_rep_w-1:0]      r_rep_cnt;
  logic [c_rep_w-1:0]      w_rep_cnt;
  logic [31:0]             r_prev;
  logic                    r_prev_valid;
  logic                    r_rep_fail;
  logic [31:0]             r_word_count;
  logic [32*NUM_WORDS-1:0] r_block;
  logic                    w_capture;
  logic                    w_last;
  logic                    w_fail_now;

  // Health-test update for the word currently on the bus.
  always_comb begin
    w_capture = enable && (r_state == S_ACK) && entropy_syn;
    w_last    = (r_idx == c_last_idx);
    w_rep_cnt = c_rep_one;
    if (r_prev_valid && (entropy_data == r_prev)) begin
      w_rep_cnt = (r_rep_cnt == c_rep_limit) ? c_rep_limit : r_rep_cnt + 1'b1;
    end
    w_fail_now = w_capture && (w_rep_cnt == c_rep_limit);
  end

  always_comb begin
    w_next = r_state;
    if (!enable) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (entropy_enabled && entropy_syn && !r_rep_fail) w_next = S_ACK;
        S_ACK:  w_next = (w_capture && w_last && !w_fail_now) ? S_FULL : S_IDLE;
        S_FULL: if (block_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_rep_cnt    <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_rep_fail   <= 1'b0;
      r_word_count <= '0;
      r_block      <= '0;
    end else if (!enable) begin
      // Flush keeps the lifetime word count and the last block contents.
      r_idx        <= '0;
      r_rep_cnt    <= '0;
      r_prev_valid <= 1'b0;
      r_rep_fail   <= 1'b0;
    end else if (w_capture) begin
      r_block[32*(NUM_WORDS-1-int'(r_idx)) +: 32] <= entropy_data;
      r_word_count <= r_word_count + 32'd1;
      r_prev       <= entropy_data;
      r_prev_valid <= 1'b1;
      r_rep_cnt    <= w_rep_cnt;
      if (w_fail_now) begin
        r_rep_fail <= 1'b1;
        r_idx      <= '0;
      end else if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign entropy_ack = (r_state == S_ACK);
  assign block_valid = (r_state == S_FULL);
  assign block_data  = r_block;
  assign rep_fail    = r_rep_fail;
  assign word_count  = r_word_count;

endmodule
`default_nettype wire

// File: tb/tb_entropy_collector.sv
`default_nettype none
// ============================================================================
// Module  : tb_entropy_collector
// Brief   : Directed bench for entropy_collector with a word-queue reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_entropy_collector;

  localparam int N   = 16;
  localparam int REP = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic           entropy_enabled = 1'b0;
  logic           entropy_syn = 1'b0;
  logic [31:0]    entropy_data = 32'd0;
  logic           block_ready = 1'b0;
  logic           entropy_ack;
  logic           block_valid;
  logic [32*N-1:0] block_data;
  logic           rep_fail;
  logic [31:0]    word_count;

  int checks = 0;
  int errors = 0;
  bit counter_mode = 1'b1;
  int blk_words = 0;

  entropy_collector #(.NUM_WORDS(N), .REP_LIMIT(REP)) dut (
    .clk(clk), .reset(reset), .enable(enable), .entropy_enabled(entropy_enabled),
    .entropy_syn(entropy_syn), .entropy_data(entropy_data), .entropy_ack(entropy_ack),
    .block_valid(block_valid), .block_data(block_data), .block_ready(block_ready),
    .rep_fail(rep_fail), .word_count(word_count)
  );

  always #5 clk = ~clk;

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [32*N-1:0] act, input logic [32*N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: words accepted so far in the current block, held block, run length.
  bit              m_ack = 1'b0;
  bit              m_hold = 1'b0;
  bit              m_fail = 1'b0;
  logic [31:0]     m_count = 32'd0;
  logic [31:0]     m_last = 32'd0;
  int              m_run = 0;
  logic [31:0]     m_words[$];
  logic [32*N-1:0] m_block = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ack = 1'b0; m_hold = 1'b0; m_fail = 1'b0;
      m_count = 32'd0; m_run = 0; m_words.delete();
    end else if (!enable) begin
      m_ack = 1'b0; m_hold = 1'b0; m_fail = 1'b0; m_run = 0; m_words.delete();
    end else if (m_hold) begin
      if (block_ready) m_hold = 1'b0;
    end else if (m_ack) begin
      m_ack = 1'b0;
      if (entropy_syn) begin
        m_count = m_count + 32'd1;
        if (m_run > 0 && entropy_data == m_last) m_run = (m_run + 1 > REP) ? REP : m_run + 1;
        else m_run = 1;
        m_last = entropy_data;
        if (m_run == REP) begin
          m_fail = 1'b1;
          m_words.delete();
        end else begin
          m_words.push_back(entropy_data);
          if (m_words.size() == N) begin
            for (int i = 0; i < N; i++) m_block[32*(N-1-i) +: 32] = m_words[i];
            m_words.delete();
            m_hold = 1'b1;
          end
        end
      end
    end else if (entropy_enabled && entropy_syn && !m_fail) begin
      m_ack = 1'b1;
    end
  end

  always @(negedge clk) begin
    check1("cyc_entropy_ack", entropy_ack, m_ack);
    check1("cyc_block_valid", block_valid, m_hold);
    check1("cyc_rep_fail", rep_fail, m_fail);
    check32("cyc_word_count", word_count, m_count);
    if (m_hold) checkw("cyc_block_data", block_data, m_block);
  end

  task automatic tick();
    logic xfer;
    xfer = entropy_ack && entropy_syn && enable;
    @(posedge clk);
    #1;
    if (xfer) begin
      blk_words++;
      if (counter_mode) entropy_data = entropy_data + 32'd1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!block_valid && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (!block_valid) begin
      errors++;
      $display("FAIL wait_block_valid: still low after %0d cycles", budget);
    end
  endtask

  initial begin
    bit dropped;
    repeat (3) @(posedge clk);
    #1;
    check1("rst_ack", entropy_ack, 1'b0);
    check1("rst_valid", block_valid, 1'b0);
    check1("rst_rep_fail", rep_fail, 1'b0);
    check32("rst_word_count", word_count, 32'd0);
    checkw("rst_block_data", block_data, '0);
    reset = 1'b0;

    // Counter source, ready held high.
    entropy_data = 32'd1; enable = 1'b1; entropy_enabled = 1'b1;
    entropy_syn = 1'b1; block_ready = 1'b1;
    wait_valid(100);
    check32("t1_msw", block_data[32*N-1 -: 32], 32'h1);
    check32("t1_lsw", block_data[31:0], 32'h10);
    check32("t1_count", word_count, 32'd16);
    tick();
    check1("t1_valid_drop", block_valid, 1'b0);

    // Back-pressure: block held while ready is low.
    block_ready = 1'b0;
    wait_valid(100);
    repeat (20) tick();
    check32("t2_count_held", word_count, 32'd32);
    check32("t2_msw", block_data[32*N-1 -: 32], 32'h11);
    check32("t2_lsw", block_data[31:0], 32'h20);
    block_ready = 1'b1;
    tick();
    wait_valid(100);
    check32("t2_next_msw", block_data[32*N-1 -: 32], 32'h21);
    tick();

    // Syn dropped during the ack of the fifth word.
    enable = 1'b0;
    tick();
    enable = 1'b1;
    blk_words = 0;
    dropped = 1'b0;
    for (int n = 0; n < 200 && !block_valid; n++) begin
      if (entropy_ack && blk_words == 4 && !dropped) begin
        entropy_syn = 1'b0;
        dropped = 1'b1;
        tick();
        entropy_syn = 1'b1;
      end else begin
        tick();
      end
    end
    wait_valid(1);
    check32("t3_slot4", block_data[32*(N-5) +: 32], 32'h35);
    check32("t3_lsw", block_data[31:0], 32'h40);
    check32("t3_count", word_count, 32'd64);
    tick();

    // Constant source trips the repetition test.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    counter_mode = 1'b0;
    entropy_data = 32'h01020304;
    repeat (30) tick();
    check1("t4_rep_fail", rep_fail, 1'b1);
    check32("t4_count", word_count, 32'd4);
    check1("t4_no_valid", block_valid, 1'b0);

    // Flush clears the failure; collection resumes.
    enable = 1'b0;
    tick();
    check1("t5_fail_clear", rep_fail, 1'b0);
    enable = 1'b1;
    counter_mode = 1'b1;
    entropy_data = 32'h100;
    wait_valid(100);
    check32("t5_msw", block_data[32*N-1 -: 32], 32'h100);
    check32("t5_lsw", block_data[31:0], 32'h10f);
    check32("t5_count", word_count, 32'd20);
    tick();

    // Asynchronous reset with seven words in the partial block.
    blk_words = 0;
    for (int n = 0; n < 100 && blk_words < 7; n++) tick();
    #2;
    reset = 1'b1;
    #1;
    check1("t6_rst_ack", entropy_ack, 1'b0);
    check1("t6_rst_valid", block_valid, 1'b0);
    check32("t6_rst_count", word_count, 32'd0);
    checkw("t6_rst_block", block_data, '0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Flush while a block is held.
    block_ready = 1'b0;
    wait_valid(100);
    check32("t7_count", word_count, 32'd16);
    enable = 1'b0;
    tick();
    check1("t7_valid_flushed", block_valid, 1'b0);
    check32("t7_count_kept", word_count, 32'd16);
    enable = 1'b1;
    block_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
`default_nettype wire
